clk_gate_ctrl: RTL



---
 rtl/clk_gate_ctrl_pkg.sv | 14 +
 rtl/clk_gate_ch_fsm.sv | 95 +++++++++
 rtl/clk_gate_ctrl.sv | 47 ++++
 3 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// rtl/clk_gate_ctrl_pkg.sv - shared types and constants for the clock-gating controller
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } ch_state_t;

    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

endpackage

// File: rtl/clk_gate_ch_fsm.sv
// rtl/clk_gate_ch_fsm.sv - one channel's gating FSM, idle counter and optional gated-cycle counter (CLKGATE_STATS_EN)
module clk_gate_ch_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thr,
    input  logic                  req,
    input  logic                  busy,
`ifdef CLKGATE_STATS_EN
    input  logic                  stats_clr,
    output logic [STATS_W-1:0]    gated_cycles,
`endif
    output logic                  ack,
    output logic                  clk_en
);

    localparam logic [IDLE_CNT_W-1:0] CNT_ONE = 1;

    ch_state_t             state_q, state_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  wake_cond;

    assign wake_cond = req | busy | ~cfg_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_en  = 1'b1;
        ack     = 1'b1;
        case (state_q)
            RUN: begin
                if (!wake_cond) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                // Activity beats the threshold compare when both happen together.
                if (wake_cond) begin
                    state_d = RUN;
                end else if (cnt_q >= cfg_idle_thr) begin
                    state_d = GATED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GATED: begin
                clk_en = 1'b0;
                ack    = 1'b0;
                if (wake_cond) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                // Clock is back but held one cycle for the gating latch to settle.
                ack     = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

`ifdef CLKGATE_STATS_EN
    logic [STATS_W-1:0] stats_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats_q <= '0;
        end else if (stats_clr) begin
            stats_q <= '0;
        end else if (state_q == GATED && stats_q != STATS_MAX) begin
            stats_q <= stats_q + 16'd1;
        end
    end

    assign gated_cycles = stats_q;
`endif

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel automatic clock-gating controller; stats ports under CLKGATE_STATS_EN
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IDLE_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    test_en_i,
    input  logic [NUM_CH-1:0]       cfg_en_i,
    input  logic [IDLE_CNT_W-1:0]   cfg_idle_thr_i,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH-1:0]       busy_i,
`ifdef CLKGATE_STATS_EN
    input  logic                    stats_clr_i,
    output logic [NUM_CH*STATS_W-1:0] gated_cycles_o,
`endif
    output logic [NUM_CH-1:0]       ack_o,
    output logic [NUM_CH-1:0]       clk_en_o
);

    logic [NUM_CH-1:0] fsm_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gate_ch_fsm #(
            .IDLE_CNT_W (IDLE_CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .cfg_en       (cfg_en_i[i]),
            .cfg_idle_thr (cfg_idle_thr_i),
            .req          (req_i[i]),
            .busy         (busy_i[i]),
`ifdef CLKGATE_STATS_EN
            .stats_clr    (stats_clr_i),
            .gated_cycles (gated_cycles_o[i*STATS_W +: STATS_W]),
`endif
            .ack          (ack_o[i]),
            .clk_en       (fsm_en[i])
        );
    end

    // Test mode overrides the enable only; FSM state and ack are untouched.
    assign clk_en_o = fsm_en | {NUM_CH{test_en_i}};

endmodule
